// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_pkg
// Brief    : Shared state encodings and default width for the sequential
//            restoring divider controller.
// Revision : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    // Default operand/result width
    localparam int DIV_W = 8;

    // State encodings (also exposed on state_o for debug/LED display)
    localparam logic [2:0] C_ST_IDLE = 3'b000;
    localparam logic [2:0] C_ST_ITER = 3'b001;
    localparam logic [2:0] C_ST_DONE = 3'b010;
    localparam logic [2:0] C_ST_ERR  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE = C_ST_IDLE,
        S_ITER = C_ST_ITER,
        S_DONE = C_ST_DONE,
        S_ERR  = C_ST_ERR
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring shift-subtract step. The partial
//            remainder/quotient pair is shifted left by one, and the divisor
//            is subtracted when it fits, shifting a 1 into the quotient.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_trial;

    // {rem,quo} << 1 keeps the bit carried out of rem as the (WIDTH+1)th bit;
    // when the divisor fits, the true difference is below div, so the low
    // WIDTH bits of the subtraction are exact.
    always_comb begin
        w_shift = {rem, quo[WIDTH-1]};
        w_fits  = (w_shift >= {1'b0, div});
        w_trial = w_shift[WIDTH-1:0] - div;
        rem_nxt = w_fits ? w_trial : w_shift[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], w_fits};
    end

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl
// Brief    : Sequencing controller for an iterative restoring divider.
//            Accepts start in IDLE, runs WIDTH shift-subtract cycles, then
//            pulses done with quotient/remainder held until the next start.
//            Optional macro DIV_ZERO_CHECK_EN: a zero divisor short-circuits
//            to ERR (done one cycle after start, div_zero=1).
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [2:0]       state_o
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign state_o   = r_state;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .div     (r_div),
        .rem_nxt (w_rem_nxt),
        .quo_nxt (w_quo_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; busy/done are pure functions of the current state
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                    w_state_nxt = (divisor == '0) ? S_ERR : S_ITER;
`else
                    w_state_nxt = S_ITER;
`endif
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
`ifdef DIV_ZERO_CHECK_EN
            S_ERR: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration registers and result holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
            r_cnt <= C_CNT_INIT;
`ifdef DIV_ZERO_CHECK_EN
            // ERR is entered on this same edge, so its results load now
            if (divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
            end
`endif
        end else if (r_state == S_ITER) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - C_CNT_ONE;
            // Final step: results land together with the entry into DONE
            if (r_cnt == '0) begin
                r_quotient  <= w_quo_nxt;
                r_remainder <= w_rem_nxt;
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic r_div_zero;

    // Zero-divisor flag: set or cleared on every accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= (divisor == '0);
        end
    end

    assign div_zero = r_div_zero;
`else
    assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq_ctrl
// Brief    : Self-checking bench for div_seq_ctrl (WIDTH=8): directed vector
//            table, multi-cycle corner sequences and randomized operations
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic [2:0]   state_o;

    int n_tests;
    int n_fail;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer division; a zero divisor yields all ones / dividend
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? ((1 << W) - 1) : (a / b);
    endfunction
    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : (a % b);
    endfunction
    function automatic int ref_lat(input int b);
`ifdef DIV_ZERO_CHECK_EN
        return (b == 0) ? 1 : W + 1;
`else
        return W + 1;
`endif
    endfunction
    function automatic int ref_busy(input int b);
`ifdef DIV_ZERO_CHECK_EN
        return (b == 0) ? 0 : W;
`else
        return W;
`endif
    endfunction
    function automatic int ref_dz(input int b);
`ifdef DIV_ZERO_CHECK_EN
        return (b == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One start pulse; returns done latency (0 = timed out) and busy-cycle count.
    // Operands are scrambled after capture; they must have no effect.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int nbusy);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat      = 0;
        nbusy    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Apply one operation and check it completely against the model
    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int nbusy;
        int dz;
        do_op(a, b, lat, nbusy);
        chk({tag, "_lat"},  lat,            ref_lat(int'(b)));
        chk({tag, "_busy"}, nbusy,          ref_busy(int'(b)));
        chk({tag, "_q"},    int'(quotient), ref_q(int'(a), int'(b)));
        chk({tag, "_r"},    int'(remainder), ref_r(int'(a), int'(b)));
        chk({tag, "_dz"},   int'(div_zero), ref_dz(int'(b)));
        dz = int'(div_zero);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done),    0);
        chk({tag, "_idle"},       int'(state_o), 0);
        chk({tag, "_dz_hold"},    int'(div_zero), dz);
    endtask

    vec_t tbl[9];

    initial begin
        int lat;
        int nbusy;
        int ndone;
        int first;
        int second;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        tbl[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2};
        tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
        tbl[2] = '{a: 8'd5,   b: 8'd10,  q: 8'd0,   r: 8'd5};
        tbl[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0};
        tbl[4] = '{a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200};
        tbl[5] = '{a: 8'd7,   b: 8'd7,   q: 8'd1,   r: 8'd0};
        tbl[6] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254};
        tbl[7] = '{a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15};
        tbl[8] = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state_o), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_q",     int'(quotient), 0);
        chk("rst_r",     int'(remainder), 0);
        chk("rst_dz",    int'(div_zero), 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, lat, nbusy);
            chk($sformatf("tbl%0d_lat", i),  lat, ref_lat(int'(tbl[i].b)));
            chk($sformatf("tbl%0d_busy", i), nbusy, ref_busy(int'(tbl[i].b)));
            chk($sformatf("tbl%0d_q", i),    int'(quotient), int'(tbl[i].q));
            chk($sformatf("tbl%0d_r", i),    int'(remainder), int'(tbl[i].r));
            chk($sformatf("tbl%0d_dz", i),   int'(div_zero), ref_dz(int'(tbl[i].b)));
            @(negedge clk);
            chk($sformatf("tbl%0d_done_pulse", i), int'(done), 0);
        end

        // Back-to-back with start held high: 255/1 then 5/10
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 8'd1;
        ndone = 0; first = 0; second = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first = k;
                    chk("b2b_q1", int'(quotient), 255);
                    chk("b2b_r1", int'(remainder), 0);
                    dividend = 8'd5; divisor = 8'd10;
                end else if (ndone == 2) begin
                    second = k;
                    chk("b2b_q2", int'(quotient), 0);
                    chk("b2b_r2", int'(remainder), 5);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_lat", first, W + 1);
        chk("b2b_period", second - first, W + 2);
        chk("b2b_ndone", ndone, 2);

        // start re-asserted mid-ITER with other operands is ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        lat = 0; ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd3; end
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    chk("midstart_q", int'(quotient), 14);
                    chk("midstart_r", int'(remainder), 2);
                end
            end
        end
        chk("midstart_lat", lat, W + 1);
        chk("midstart_ndone", ndone, 1);

        // Reset at cycle 4 of an operation aborts it without a done pulse
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        ndone = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                chk("abort_state", int'(state_o), 0);
                chk("abort_busy",  int'(busy), 0);
                chk("abort_q",     int'(quotient), 0);
                chk("abort_r",     int'(remainder), 0);
                rst = 1'b0;
            end
            if (done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        run_check("after_abort", 8'd9, 8'd3);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 8'd1;
                2:       rb = ra;
                default: rb = W'($urandom);
            endcase
            run_check($sformatf("rnd%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequencing controller for the processor's iterative divide datapath. Accepts a start request with dividend and divisor, then runs a restoring shift-subtract division for WIDTH cycles. Returns quotient and remainder with a one-cycle done pulse. Sits between the top-level control FSM, which raises start, and the result/display stage, which consumes done, quotient and remainder.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  captured on the accepted start edge
divisor  input  WIDTH  captured on the accepted start edge
busy  output  1  high while in ITER
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  result, held until next accepted start
remainder  output  WIDTH  result, held until next accepted start
div_zero  output  1  divisor-zero flag, valid with done, held with results
state_o  output  3  current state encoding, for debug/LED display

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_zero=0; quotient=0, remainder=0; counter=0. Reset mid-operation aborts immediately; no done is generated.
- States: IDLE=3'b000, ITER=3'b001, DONE=3'b010, ERR=3'b011. Other codes go to IDLE.
- IDLE:
  - start=1: capture operands; rem_r=0, quo_r=dividend, div_r=divisor, cnt=WIDTH-1.
  - Next state: ITER, or ERR if the feature is enabled and divisor==0.
  - start=0: stay in IDLE.
- ITER, one restoring step per cycle:
  - {rem,quo} shifted left 1.
  - trial = shifted rem - div_r, computed in WIDTH+1 bits.
  - trial non-negative: rem=trial[WIDTH-1:0], quo LSB=1. Otherwise rem=shifted rem, quo LSB=0.
  - cnt decrements each step. When cnt==0 the step executes and next state is DONE.
- ITER lasts exactly WIDTH cycles. done is high in the (WIDTH+1)th cycle after the start edge.
- DONE: done=1 for one cycle; quotient/remainder registers load from quo_r/rem_r on entry to DONE. Next state: IDLE unconditionally.
- ERR: done=1 and div_zero=1 for one cycle; quotient=all ones, remainder=dividend. Next state: IDLE.
- start while not in IDLE (ITER/DONE/ERR) is ignored, not queued. Operand changes after capture have no effect.
- start held high continuously: a new operation is accepted on each IDLE cycle, giving back-to-back operations with a WIDTH+2 cycle period.
- div_zero clears on the next accepted start.
- Boundary results:
  - divisor > dividend gives q=0, r=dividend.
  - divisor=1 gives q=dividend, r=0.
  - dividend=0 gives q=0, r=0.

Optional Feature:
DIV_ZERO_CHECK_EN
- Defined: a zero divisor detected at start goes to ERR, with done in the cycle after start and div_zero=1.
- Not defined:
  - ERR state is absent and div_zero is tied to 0.
  - A zero divisor runs the normal WIDTH iterations.
  - Restoring arithmetic naturally yields quotient=all ones, remainder=dividend, with done at cycle WIDTH+1.
- Results identical in both builds; only latency and flag differ.

Decomposition:
- Package div_seq_pkg holds:
  - State encodings: IDLE, ITER, DONE, ERR, as 3-bit localparams.
  - Default width constant DIV_W=8.
- Natural sub-module: div_step, a combinational single shift-subtract step.
  - Inputs: rem, quo, div.
  - Outputs: next rem, next quo.
  - The controller instantiates one copy and registers its outputs.

Test Plan:
- 100/7, WIDTH=8, start pulsed 1 cycle -> busy high 8 cycles; done at cycle 9; q=14, r=2.
- 255/1 then 5/10 back-to-back with start held high -> q=255,r=0; then q=0,r=5; period 10 cycles; exactly one done per operation.
- 200/0, built with DIV_ZERO_CHECK_EN -> done at cycle 1, div_zero=1, q=255, r=200.
- 200/0, built without DIV_ZERO_CHECK_EN -> done at cycle 9, div_zero=0, q=255, r=200.
- start re-asserted with new operands mid-ITER (cycle 3) -> ignored; original result 100/7 delivered unchanged.
- rst asserted at cycle 4 of an operation -> next cycle state_o=000, busy=0, q=r=0; no done pulse; a following 9/3 gives q=3, r=0.
